vga_timing_rx: RTL and testbench



---
 rtl/vga_timing_rx_if.sv | 27 ++
 rtl/vga_timing_rx.sv | 216 +++++++++++++++++++++
 tb/tb_vga_timing_rx.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/vga_timing_rx_if.sv
// Video timing bundle between a sync source (hsync/vsync/blank) and the
// timing receiver that reports recovered coordinates, measurements and lock.
interface vga_timing_rx_if #(
  parameter int H_W = 11,
  parameter int V_W = 10
);
  logic           hsync;
  logic           vsync;
  logic           blank;
  logic [H_W-1:0] x;
  logic [V_W-1:0] y;
  logic           active;
  logic [H_W-1:0] line_period;
  logic [V_W-1:0] frame_lines;
  logic           locked;
  logic           sync_err;

  modport master (
    output hsync, vsync, blank,
    input  x, y, active, line_period, frame_lines, locked, sync_err
  );

  modport slave (
    input  hsync, vsync, blank,
    output x, y, active, line_period, frame_lines, locked, sync_err
  );
endinterface

// File: rtl/vga_timing_rx.sv
// Video timing receiver: recovers pixel coordinates from hsync/vsync/blank,
// measures line period and lines per frame, and tracks lock on stable timing.
module vga_timing_rx #(
  parameter int H_W     = 11,
  parameter int V_W     = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_timing_rx_if.slave vid
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [H_W-1:0]  H_ONE    = H_W'(1);
  localparam logic [V_W-1:0]  V_ONE    = V_W'(1);
  localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  logic           hs_q, vs_q, bk_q;
  logic           hs_qq, vs_qq;
  logic           in_vld_q;

  logic [H_W-1:0] hcnt_q, hcnt_d;
  logic [H_W-1:0] line_period_q, line_period_d;
  logic [H_W-1:0] first_period_q, first_period_d;
  logic [H_W-1:0] x_q, x_d;
  logic [V_W-1:0] vcnt_q, vcnt_d;
  logic [V_W-1:0] frame_lines_q, frame_lines_d;
  logic [V_W-1:0] y_q, y_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic           lp_valid_q, lp_valid_d;
  logic           first_valid_q, first_valid_d;
  logic           line_ok_q, line_ok_d;
  logic           active_q, active_d;

  state_t         state_q;
  logic [H_W-1:0] ref_period_q;
  logic [V_W-1:0] ref_lines_q;
  logic           ref_valid_q;
  logic           locked_q;
  logic           sync_err_q;

  logic           hs_rise, vs_rise, y_step, timeout;
  logic           period_chk, line_bad, frame_ok, ref_match;
  logic [H_W-1:0] hcnt_inc;
  logic [V_W-1:0] vcnt_add;

  // active_q doubles as the delayed blank: a blank rise while active_q is set
  // is exactly a blank rise that follows a visible pixel.
  assign hs_rise    = hs_q & ~hs_qq;
  assign vs_rise    = vs_q & ~vs_qq;
  assign y_step     = bk_q & active_q;
  assign timeout    = (wd_q == WD_LIMIT);
  assign hcnt_inc   = (&hcnt_q) ? hcnt_q : hcnt_q + H_ONE;
  assign vcnt_add   = (hs_rise && !(&vcnt_q)) ? vcnt_q + V_ONE : vcnt_q;
  assign period_chk = hs_rise & lp_valid_q;
  assign line_bad   = period_chk & first_valid_q & (hcnt_inc != first_period_q);
  assign frame_ok   = line_ok_q & ~line_bad & (first_valid_q | period_chk);
  assign ref_match  = ref_valid_q && (line_period_d == ref_period_q) &&
                      (frame_lines_d == ref_lines_q);

  // Horizontal/vertical measurement, per-frame line consistency and watchdog.
  always_comb begin
    hcnt_d         = hs_rise ? '0 : hcnt_inc;
    line_period_d  = hs_rise ? hcnt_inc : line_period_q;
    wd_d           = hs_rise ? '0 : (timeout ? wd_q : wd_q + WD_ONE);
    lp_valid_d     = timeout ? 1'b0 : (hs_rise ? 1'b1 : lp_valid_q);

    vcnt_d         = vs_rise ? '0 : vcnt_add;
    frame_lines_d  = vs_rise ? vcnt_add : frame_lines_q;

    first_valid_d  = first_valid_q;
    first_period_d = first_period_q;
    if (vs_rise) begin
      first_valid_d = 1'b0;
    end else if (period_chk && !first_valid_q) begin
      first_valid_d  = 1'b1;
      first_period_d = hcnt_inc;
    end
    line_ok_d = vs_rise ? 1'b1 : (line_bad ? 1'b0 : line_ok_q);
  end

  // Coordinate recovery; x restarts at 0 on the first visible pixel of a line.
  always_comb begin
    active_d = ~bk_q & in_vld_q;
    x_d      = '0;
    if (!bk_q && active_q) begin
      x_d = (&x_q) ? x_q : x_q + H_ONE;
    end
    y_d = y_q;
    if (vs_rise) begin
      y_d = '0;
    end else if (y_step && !(&y_q)) begin
      y_d = y_q + V_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q           <= 1'b0;
      vs_q           <= 1'b0;
      bk_q           <= 1'b0;
      hs_qq          <= 1'b0;
      vs_qq          <= 1'b0;
      in_vld_q       <= 1'b0;
      hcnt_q         <= '0;
      line_period_q  <= '0;
      first_period_q <= '0;
      x_q            <= '0;
      vcnt_q         <= '0;
      frame_lines_q  <= '0;
      y_q            <= '0;
      wd_q           <= '0;
      lp_valid_q     <= 1'b0;
      first_valid_q  <= 1'b0;
      line_ok_q      <= 1'b0;
      active_q       <= 1'b0;
    end else begin
      hs_q           <= vid.hsync;
      vs_q           <= vid.vsync;
      bk_q           <= vid.blank;
      hs_qq          <= hs_q;
      vs_qq          <= vs_q;
      in_vld_q       <= 1'b1;
      hcnt_q         <= hcnt_d;
      line_period_q  <= line_period_d;
      first_period_q <= first_period_d;
      x_q            <= x_d;
      vcnt_q         <= vcnt_d;
      frame_lines_q  <= frame_lines_d;
      y_q            <= y_d;
      wd_q           <= wd_d;
      lp_valid_q     <= lp_valid_d;
      first_valid_q  <= first_valid_d;
      line_ok_q      <= line_ok_d;
      active_q       <= active_d;
    end
  end

  // Lock tracking. Decisions use the measurements as they are being updated
  // this cycle, so a vsync edge is judged against the frame it just closed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SEARCH;
      ref_period_q <= '0;
      ref_lines_q  <= '0;
      ref_valid_q  <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      sync_err_q <= 1'b0;
      if (timeout) begin
        if (state_q == LOCKED) begin
          sync_err_q <= 1'b1;
        end
        state_q     <= SEARCH;
        locked_q    <= 1'b0;
        ref_valid_q <= 1'b0;
      end else begin
        case (state_q)
          SEARCH: begin
            locked_q <= 1'b0;
            if (vs_rise) begin
              state_q      <= TRACK;
              ref_period_q <= '0;
              ref_lines_q  <= '0;
              ref_valid_q  <= 1'b0;
            end
          end
          TRACK: begin
            locked_q <= 1'b0;
            if (vs_rise) begin
              if (frame_ok && ref_match) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end else begin
                ref_period_q <= line_period_d;
                ref_lines_q  <= frame_lines_d;
                ref_valid_q  <= frame_ok;
              end
            end
          end
          LOCKED: begin
            locked_q <= 1'b1;
            if ((period_chk && (line_period_d != ref_period_q)) ||
                (vs_rise && (frame_lines_d != ref_lines_q))) begin
              sync_err_q  <= 1'b1;
              state_q     <= TRACK;
              locked_q    <= 1'b0;
              ref_valid_q <= 1'b0;
            end
          end
          default: begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.active      = active_q;
  assign vid.line_period = line_period_q;
  assign vid.frame_lines = frame_lines_q;
  assign vid.locked      = locked_q;
  assign vid.sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx: a randomly sized raster with stretched lines, short
// frames, sync loss and mid-line reset, compared against raster-level expectations.
module tb_vga_timing_rx;

  localparam int H_W     = 11;
  localparam int V_W     = 10;
  localparam int TIMEOUT = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_rx_if #(.H_W(H_W), .V_W(V_W)) vid();

  vga_timing_rx #(.H_W(H_W), .V_W(V_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vid   (vid)
  );

  int total = 0;
  int bad   = 0;

  int h_tot, h_act, hs_start, hs_end;
  int v_tot, v_act, vs_start, vs_end;

  logic pa [2];
  int   px [2];
  int   py [2];
  int   cyc, err_cnt, vs_cyc, lock_cyc;
  logic prev_locked, prev_vs;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic reset_pipe();
    for (int i = 0; i < 2; i++) begin
      pa[i] = 1'b0;
      px[i] = 0;
      py[i] = 0;
    end
    prev_locked = 1'b0;
    prev_vs     = 1'b0;
  endtask

  // One pixel clock: sample outputs against what was driven two clocks ago,
  // then drive the next input sample.
  task automatic apply_stimulus(input logic hs, input logic vs, input logic bk,
                                input logic ea, input int ex, input int ey);
    @(negedge clk);
    if (vid.sync_err === 1'b1) err_cnt++;
    if (vid.locked === 1'b1 && !prev_locked) lock_cyc = cyc;
    prev_locked = (vid.locked === 1'b1);
    check_output("active", {31'd0, vid.active}, {31'd0, pa[1]});
    check_output("x", {21'd0, vid.x}, px[1]);
    if (pa[1]) check_output("y", {22'd0, vid.y}, py[1]);
    pa[1] = pa[0]; px[1] = px[0]; py[1] = py[0];
    pa[0] = ea;    px[0] = ex;    py[0] = ey;
    if (vs && !prev_vs) vs_cyc = cyc;
    prev_vs   = vs;
    vid.hsync = hs;
    vid.vsync = vs;
    vid.blank = bk;
    cyc++;
  endtask

  task automatic drive_pixel(input int h, input int v);
    logic act, hs, vs;
    act = (h < h_act) && (v < v_act);
    hs  = (h >= hs_start) && (h < hs_end);
    vs  = (v >= vs_start) && (v < vs_end);
    apply_stimulus(hs, vs, !act, act, act ? h : 0, v);
  endtask

  task automatic run_frame(input string tag, input int lines, input int stretch_line,
                           input int extra, input logic exp_lock, input int exp_lines,
                           input int exp_errs);
    int errs0, len;
    errs0 = err_cnt;
    for (int v = 0; v < lines; v++) begin
      len = h_tot + ((v == stretch_line) ? extra : 0);
      for (int h = 0; h < len; h++) drive_pixel(h, v);
    end
    check_output({tag, ".locked"}, {31'd0, vid.locked}, {31'd0, exp_lock});
    check_output({tag, ".frame_lines"}, {22'd0, vid.frame_lines}, exp_lines);
    check_output({tag, ".line_period"}, {21'd0, vid.line_period}, h_tot);
    check_output({tag, ".sync_err_pulses"}, err_cnt - errs0, exp_errs);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, ".x"}, {21'd0, vid.x}, 0);
    check_output({tag, ".y"}, {22'd0, vid.y}, 0);
    check_output({tag, ".active"}, {31'd0, vid.active}, 0);
    check_output({tag, ".line_period"}, {21'd0, vid.line_period}, 0);
    check_output({tag, ".frame_lines"}, {22'd0, vid.frame_lines}, 0);
    check_output({tag, ".locked"}, {31'd0, vid.locked}, 0);
    check_output({tag, ".sync_err"}, {31'd0, vid.sync_err}, 0);
  endtask

  initial begin
    int st_line, st_extra, r_line, r_h, errs0;

    h_act    = $urandom_range(12, 24);
    h_tot    = h_act + $urandom_range(10, 16);
    hs_start = h_act + 2;
    hs_end   = hs_start + 4;
    v_act    = $urandom_range(6, 10);
    vs_start = v_act + 1;
    vs_end   = vs_start + 2;
    v_tot    = vs_end + $urandom_range(2, 4);
    $display("[TB] raster h_tot=%0d h_act=%0d v_tot=%0d v_act=%0d", h_tot, h_act, v_tot, v_act);

    cyc = 0; err_cnt = 0; vs_cyc = 0; lock_cyc = -100;
    vid.hsync = 1'b0; vid.vsync = 1'b0; vid.blank = 1'b1;
    reset_pipe();

    // Reset state, then acquisition over three vsync edges.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    reset_pipe();
    run_frame("acq1", v_tot, -1, 0, 1'b0, vs_start, 0);
    run_frame("acq2", v_tot, -1, 0, 1'b0, v_tot, 0);
    run_frame("acq3", v_tot, -1, 0, 1'b1, v_tot, 0);
    check_output("acq.lock_delay", lock_cyc - vs_cyc, 2);
    run_frame("clean", v_tot, -1, 0, 1'b1, v_tot, 0);

    // One stretched line while locked.
    st_line  = $urandom_range(0, vs_start - 2);
    st_extra = $urandom_range(1, 3);
    run_frame("stretch", v_tot, st_line, st_extra, 1'b0, v_tot, 1);
    run_frame("stretch_r1", v_tot, -1, 0, 1'b0, v_tot, 0);
    run_frame("stretch_r2", v_tot, -1, 0, 1'b1, v_tot, 0);

    // A frame one line short, seen at the following vsync edge.
    run_frame("short", v_tot - 1, -1, 0, 1'b1, v_tot, 0);
    run_frame("short_seen", v_tot, -1, 0, 1'b0, v_tot - 1, 1);
    run_frame("short_r1", v_tot, -1, 0, 1'b0, v_tot, 0);
    run_frame("short_r2", v_tot, -1, 0, 1'b1, v_tot, 0);

    // Loss of hsync long enough to trip the watchdog.
    errs0 = err_cnt;
    for (int i = 0; i < 300; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    check_output("wd.sync_err_pulses", err_cnt - errs0, 1);
    check_output("wd.locked", {31'd0, vid.locked}, 0);
    check_output("wd.line_period_held", {21'd0, vid.line_period}, h_tot);
    check_output("wd.frame_lines_held", {22'd0, vid.frame_lines}, v_tot);
    run_frame("wd_r1", v_tot, -1, 0, 1'b0, v_tot, 0);
    run_frame("wd_r2", v_tot, -1, 0, 1'b0, v_tot, 0);
    run_frame("wd_r3", v_tot, -1, 0, 1'b1, v_tot, 0);
    check_output("wd.lock_delay", lock_cyc - vs_cyc, 2);

    // Asynchronous reset in the middle of a visible line while locked.
    r_line = $urandom_range(1, v_act - 1);
    r_h    = $urandom_range(2, h_act - 1);
    for (int v = 0; v < r_line; v++)
      for (int h = 0; h < h_tot; h++) drive_pixel(h, v);
    for (int h = 0; h <= r_h; h++) drive_pixel(h, r_line);
    check_output("pre_rst.locked", {31'd0, vid.locked}, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    repeat (2) @(negedge clk);
    vid.hsync = 1'b0; vid.vsync = 1'b0; vid.blank = 1'b1;
    rst_n = 1'b1;
    reset_pipe();
    run_frame("rst_r1", v_tot, -1, 0, 1'b0, vs_start, 0);
    run_frame("rst_r2", v_tot, -1, 0, 1'b0, v_tot, 0);
    run_frame("rst_r3", v_tot, -1, 0, 1'b1, v_tot, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
